// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: a saturating membrane potential, fire on threshold, programmable refractory period.
// Optional saturating output-spike counter when LIF_SPIKE_COUNT_EN is defined.
module lif_neuron #(
   parameter int POT_W          = 12,
   parameter int LEAK           = 1,
   parameter int THRESHOLD      = 200,
   parameter int REFRACT_CYCLES = 4,
   parameter int COUNT_W        = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               spike_in,
   input  logic               enable,
   input  logic [7:0]         syn_weight,
   output logic               spike_out,
   output logic [POT_W-1:0]   membrane,
   output logic               refractory
`ifdef LIF_SPIKE_COUNT_EN
   ,
   output logic [COUNT_W-1:0] spike_count
`endif
);

   typedef enum logic [0:0] {INTEGRATE = 1'b0, REFRACTORY = 1'b1} state_t;

   localparam logic signed [POT_W+1:0] LEAK_S  = (POT_W+2)'(LEAK);
   localparam logic signed [POT_W+1:0] MAX_S   = {2'b00, {POT_W{1'b1}}};
   localparam logic [POT_W-1:0]        THRESH  = POT_W'(THRESHOLD);
   localparam logic [7:0]              REFRACT = 8'(REFRACT_CYCLES);

   state_t             state, state_next;
   logic [7:0]         cnt, cnt_next;
   logic [POT_W-1:0]   mem_next;
   logic               spike_next;
   logic               fire;
   logic [7:0]         weight_sel;
   logic signed [POT_W+1:0] sum;
   logic [POT_W-1:0]   clamped;

   // Two guard bits let the sum go negative or exceed the maximum before clamping.
   always_comb begin
      weight_sel = spike_in ? syn_weight : 8'd0;
      sum = $signed({2'b00, membrane}) + $signed({{(POT_W-6){1'b0}}, weight_sel}) - LEAK_S;
      if (sum < 0)
         clamped = '0;
      else if (sum > MAX_S)
         clamped = '1;
      else
         clamped = sum[POT_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= INTEGRATE;
         cnt       <= 8'd0;
         membrane  <= '0;
         spike_out <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         membrane  <= mem_next;
         spike_out <= spike_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      mem_next   = membrane;
      spike_next = 1'b0;
      fire       = 1'b0;
      if (enable) begin
         case (state)
            INTEGRATE: begin
               if (clamped >= THRESH) begin
                  fire       = 1'b1;
                  spike_next = 1'b1;
                  mem_next   = '0;
                  if (REFRACT != 8'd0) begin
                     state_next = REFRACTORY;
                     cnt_next   = REFRACT;
                  end
               end else begin
                  mem_next = clamped;
               end
            end
            REFRACTORY: begin
               mem_next = '0;
               cnt_next = cnt - 8'd1;
               if (cnt <= 8'd1) begin
                  state_next = INTEGRATE;
                  cnt_next   = 8'd0;
               end
            end
            default: state_next = INTEGRATE;
         endcase
      end
   end

   always_comb begin
      refractory = (state == REFRACTORY);
   end

`ifdef LIF_SPIKE_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         spike_count <= '0;
      else if (fire && (spike_count != {COUNT_W{1'b1}}))
         spike_count <= spike_count + 1'b1;
   end
`endif

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: a default instance, a saturation instance (THRESHOLD=4095)
// and a no-refractory instance (REFRACT_CYCLES=0) share one set of inputs.
module tb_lif_neuron;

   logic        clk = 1'b0;
   logic        rst;
   logic        spike_in;
   logic        enable;
   logic [7:0]  syn_weight;

   logic        spike_out, refractory;
   logic [11:0] membrane;
   logic        sat_spike, sat_refr;
   logic [11:0] sat_mem;
   logic        b2b_spike, b2b_refr;
   logic [11:0] b2b_mem;
`ifdef LIF_SPIKE_COUNT_EN
   logic [1:0]  spike_count;
   logic [15:0] sat_count, b2b_count;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lif_neuron #(.POT_W(12), .LEAK(1), .THRESHOLD(200), .REFRACT_CYCLES(4), .COUNT_W(2)) dut (
      .clk(clk), .rst(rst), .spike_in(spike_in), .enable(enable), .syn_weight(syn_weight),
      .spike_out(spike_out), .membrane(membrane), .refractory(refractory)
`ifdef LIF_SPIKE_COUNT_EN
      , .spike_count(spike_count)
`endif
   );

   lif_neuron #(.POT_W(12), .LEAK(1), .THRESHOLD(4095), .REFRACT_CYCLES(4), .COUNT_W(16)) dut_sat (
      .clk(clk), .rst(rst), .spike_in(spike_in), .enable(enable), .syn_weight(syn_weight),
      .spike_out(sat_spike), .membrane(sat_mem), .refractory(sat_refr)
`ifdef LIF_SPIKE_COUNT_EN
      , .spike_count(sat_count)
`endif
   );

   lif_neuron #(.POT_W(12), .LEAK(1), .THRESHOLD(50), .REFRACT_CYCLES(0), .COUNT_W(16)) dut_b2b (
      .clk(clk), .rst(rst), .spike_in(spike_in), .enable(enable), .syn_weight(syn_weight),
      .spike_out(b2b_spike), .membrane(b2b_mem), .refractory(b2b_refr)
`ifdef LIF_SPIKE_COUNT_EN
      , .spike_count(b2b_count)
`endif
   );

   // Outputs are sampled 1 ns after the rising edge; inputs change at the same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      spike_in   = 1'b0;
      enable     = 1'b1;
      syn_weight = 8'd0;
      rst        = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({spike_out, refractory, membrane} !== 14'd0) begin
         bad++;
         $display("FAIL reset: spike_out=%0b refractory=%0b membrane=%0d, want 0 0 0", spike_out, refractory, membrane);
      end
`ifdef LIF_SPIKE_COUNT_EN
      total++;
      if (spike_count !== 2'd0) begin
         bad++;
         $display("FAIL reset_count: spike_count=%0d, want 0", spike_count);
      end
`endif
   endtask

   task automatic test_threshold_refractory();
      logic [11:0] exp_mem [4] = '{12'd49, 12'd98, 12'd147, 12'd196};
      do_reset();
      syn_weight = 8'd50;
      spike_in   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         total++;
         if (membrane !== exp_mem[i] || spike_out !== 1'b0) begin
            bad++;
            $display("FAIL integrate[%0d]: membrane=%0d spike_out=%0b, want %0d 0", i, membrane, spike_out, exp_mem[i]);
         end
      end
      step();
      total++;
      if (spike_out !== 1'b1 || membrane !== 12'd0 || refractory !== 1'b1) begin
         bad++;
         $display("FAIL fire: spike_out=%0b membrane=%0d refractory=%0b, want 1 0 1", spike_out, membrane, refractory);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (spike_out !== 1'b0 || membrane !== 12'd0 || refractory !== 1'b1) begin
            bad++;
            $display("FAIL refractory[%0d]: spike_out=%0b membrane=%0d refractory=%0b, want 0 0 1", i, spike_out, membrane, refractory);
         end
      end
      step();
      total++;
      if (refractory !== 1'b0 || membrane !== 12'd0 || spike_out !== 1'b0) begin
         bad++;
         $display("FAIL refractory_exit: refractory=%0b membrane=%0d spike_out=%0b, want 0 0 0", refractory, membrane, spike_out);
      end
      step();
      total++;
      if (membrane !== 12'd49) begin
         bad++;
         $display("FAIL first_integrate: membrane=%0d, want 49", membrane);
      end
   endtask

   task automatic test_leak_floor();
      logic [11:0] exp_mem [4] = '{12'd2, 12'd1, 12'd0, 12'd0};
      do_reset();
      syn_weight = 8'd4;
      spike_in   = 1'b1;
      step();
      spike_in = 1'b0;
      total++;
      if (membrane !== 12'd3) begin
         bad++;
         $display("FAIL leak_load: membrane=%0d, want 3", membrane);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         total++;
         if (membrane !== exp_mem[i]) begin
            bad++;
            $display("FAIL leak[%0d]: membrane=%0d, want %0d", i, membrane, exp_mem[i]);
         end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      syn_weight = 8'd255;
      spike_in   = 1'b1;
      for (int i = 0; i < 16; i++) step();
      total++;
      if (sat_mem !== 12'd4064 || sat_spike !== 1'b0) begin
         bad++;
         $display("FAIL sat_16: membrane=%0d spike_out=%0b, want 4064 0", sat_mem, sat_spike);
      end
      step();
      total++;
      if (sat_spike !== 1'b1 || sat_mem !== 12'd0) begin
         bad++;
         $display("FAIL sat_fire: spike_out=%0b membrane=%0d, want 1 0", sat_spike, sat_mem);
      end
   endtask

   task automatic test_weight_change();
      do_reset();
      syn_weight = 8'd50;
      spike_in   = 1'b1;
      step();
      syn_weight = 8'd10;
      step();
      total++;
      if (membrane !== 12'd58) begin
         bad++;
         $display("FAIL weight_change: membrane=%0d, want 58", membrane);
      end
   endtask

   task automatic test_enable_freeze();
      do_reset();
      syn_weight = 8'd50;
      spike_in   = 1'b1;
      step();
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (membrane !== 12'd49) begin
            bad++;
            $display("FAIL freeze_integrate[%0d]: membrane=%0d, want 49", i, membrane);
         end
      end
      enable   = 1'b1;
      spike_in = 1'b0;
      step();
      total++;
      if (membrane !== 12'd48) begin
         bad++;
         $display("FAIL unfreeze_leak: membrane=%0d, want 48", membrane);
      end
      // Fire, then freeze one edge into refractory with two refractory edges still owed.
      do_reset();
      syn_weight = 8'd50;
      spike_in   = 1'b1;
      for (int i = 0; i < 6; i++) step();
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         total++;
         if (refractory !== 1'b1 || membrane !== 12'd0 || spike_out !== 1'b0) begin
            bad++;
            $display("FAIL freeze_refr[%0d]: refractory=%0b membrane=%0d spike_out=%0b, want 1 0 0", i, refractory, membrane, spike_out);
         end
      end
      enable = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         total++;
         if (refractory !== 1'b1) begin
            bad++;
            $display("FAIL resume_refr[%0d]: refractory=%0b, want 1", i, refractory);
         end
      end
      step();
      total++;
      if (refractory !== 1'b0) begin
         bad++;
         $display("FAIL resume_exit: refractory=%0b, want 0", refractory);
      end
      step();
      total++;
      if (membrane !== 12'd49) begin
         bad++;
         $display("FAIL resume_integrate: membrane=%0d, want 49", membrane);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      syn_weight = 8'd50;
      spike_in   = 1'b1;
      step();
      step();
      #2 rst = 1'b1;
      #1;
      total++;
      if (membrane !== 12'd0) begin
         bad++;
         $display("FAIL async_rst_integrate: membrane=%0d, want 0", membrane);
      end
      #2 rst = 1'b0;
      step();
      total++;
      if (membrane !== 12'd49) begin
         bad++;
         $display("FAIL post_rst_integrate: membrane=%0d, want 49", membrane);
      end
      for (int i = 0; i < 5; i++) step();
      #2 rst = 1'b1;
      #1;
      total++;
      if (refractory !== 1'b0 || membrane !== 12'd0 || spike_out !== 1'b0) begin
         bad++;
         $display("FAIL async_rst_refr: refractory=%0b membrane=%0d spike_out=%0b, want 0 0 0", refractory, membrane, spike_out);
      end
      #2 rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      syn_weight = 8'd60;
      spike_in   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (b2b_spike !== 1'b1 || b2b_mem !== 12'd0 || b2b_refr !== 1'b0) begin
            bad++;
            $display("FAIL back_to_back[%0d]: spike_out=%0b membrane=%0d refractory=%0b, want 1 0 0", i, b2b_spike, b2b_mem, b2b_refr);
         end
      end
   endtask

`ifdef LIF_SPIKE_COUNT_EN
   task automatic test_spike_count();
      logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      do_reset();
      syn_weight = 8'd255;
      spike_in   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if (spike_out !== 1'b1 || spike_count !== exp_cnt[i]) begin
            bad++;
            $display("FAIL spike_count[%0d]: spike_out=%0b count=%0d, want 1 %0d", i, spike_out, spike_count, exp_cnt[i]);
         end
         for (int j = 0; j < 4; j++) step();
      end
   endtask
`endif

   initial begin
      rst        = 1'b1;
      spike_in   = 1'b0;
      enable     = 1'b0;
      syn_weight = 8'd0;
      test_reset();
      test_threshold_refractory();
      test_leak_floor();
      test_saturation();
      test_weight_change();
      test_enable_freeze();
      test_async_reset();
      test_back_to_back();
`ifdef LIF_SPIKE_COUNT_EN
      test_spike_count();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
